// File: rtl/mem_access_unit_if.sv
// Request, cache-control and result handshake bundle for mem_access_unit.
// The bidirectional cache data bus stays a plain port on the unit.
interface mem_access_unit_if #(
    parameter int TAG_WIDTH = 7
);
    logic                 flush;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_store;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_address;
    logic [31:0]          req_data;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 cache_hit;
    logic [31:0]          cache_address;
    logic                 cache_read;
    logic                 cache_write;
    logic                 result_valid;
    logic                 result_ready;
    logic [31:0]          result_data;
    logic [TAG_WIDTH-1:0] result_tag;
    logic                 result_error;

    modport master (
        output flush, req_valid, req_store, req_size, req_unsigned,
        output req_address, req_data, req_tag, cache_hit, result_ready,
        input  req_ready, cache_address, cache_read, cache_write,
        input  result_valid, result_data, result_tag, result_error
    );

    modport slave (
        input  flush, req_valid, req_store, req_size, req_unsigned,
        input  req_address, req_data, req_tag, cache_hit, result_ready,
        output req_ready, cache_address, cache_read, cache_write,
        output result_valid, result_data, result_tag, result_error
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store back end: cache access, load align/extend, sub-word store RMW.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: trap misaligned half/word accesses.
module mem_access_unit #(
    parameter int TAG_WIDTH    = 7,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire  [31:0]      cache_data,
    mem_access_unit_if.slave bus
);
    localparam int CW = $clog2(MISS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE_RD,
        S_STORE_WR,
        S_RESULT
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [1:0]           size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        tmo_q, tmo_d;

    logic [31:0] req_addr_al;
    logic        req_misalign;
    logic [4:0]  shamt;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic        tmo_last;
    logic        rd_en;
    logic        wr_en;

    always_comb begin
        req_addr_al = bus.req_address;
        unique case (1'b1)
            bus.req_size == 2'b01: req_addr_al[0] = 1'b0;
            bus.req_size[1]:       req_addr_al[1:0] = 2'b00;
            default: ;
        endcase
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign req_misalign =
        (bus.req_size == 2'b01 && bus.req_address[0]) ||
        (bus.req_size[1] && bus.req_address[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    // Little-endian lane select: shift the addressed lane down to bit 0.
    assign shamt    = {addr_q[1:0], 3'b000};
    assign rd_shift = cache_data >> shamt;

    always_comb begin
        load_val = rd_shift;
        unique case (1'b1)
            size_q == 2'b00:
                load_val = unsigned_q ? {24'd0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            size_q == 2'b01:
                load_val = unsigned_q ? {16'd0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ;
        endcase
    end

    assign lane_mask = (size_q == 2'b01 ? 32'h0000_FFFF
                                        : 32'h0000_00FF) << shamt;
    assign merged    = (cache_data & ~lane_mask) |
                       ((wdata_q << shamt) & lane_mask);
    assign tmo_last  = tmo_q == CW'(MISS_TIMEOUT - 1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        tag_d      = tag_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    addr_d     = req_addr_al;
                    wdata_d    = bus.req_data;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    tag_d      = bus.req_tag;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    if (req_misalign) begin
                        err_d   = 1'b1;
                        state_d = S_RESULT;
                    end else if (!bus.req_store) begin
                        state_d = S_LOAD;
                    end else if (bus.req_size[1]) begin
                        state_d = S_STORE_WR;
                    end else begin
                        state_d = S_STORE_RD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.cache_hit) begin
                    rdata_d = load_val;
                    state_d = S_RESULT;
                end else if (tmo_last) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_STORE_RD: begin
                if (bus.cache_hit) begin
                    wdata_d = merged;
                    state_d = S_STORE_WR;
                end else if (tmo_last) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_STORE_WR: begin
                if (bus.cache_hit) begin
                    rdata_d = '0;
                    state_d = S_RESULT;
                end else if (tmo_last) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_RESULT: begin
                if (bus.result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush outranks hit and grant in the same cycle.
        if (bus.flush) state_d = S_IDLE;
        if (state_d != state_q) tmo_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            tag_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            tag_q      <= tag_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign rd_en = (state_q == S_LOAD) || (state_q == S_STORE_RD);
    assign wr_en = state_q == S_STORE_WR;

    assign bus.req_ready     = state_q == S_IDLE;
    assign bus.cache_read    = rd_en;
    assign bus.cache_write   = wr_en;
    assign bus.cache_address = (rd_en || wr_en) ? {addr_q[31:2], 2'b00}
                                                : 32'd0;
    assign cache_data        = wr_en ? wdata_q : 32'hzzzz_zzzz;

    assign bus.result_valid = state_q == S_RESULT;
    assign bus.result_data  = rdata_q;
    assign bus.result_tag   = tag_q;
    assign bus.result_error = err_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Execution back end of the load/store path: accepts one decoded memory operation (effective address, store data, size and tag) and drives the data-cache port.
- Loads: performs the cache access, then aligns and extends the returned data.
- Sub-word stores: performs read-modify-write.
- Holds the finished result (data plus tag) until the common-data-bus arbiter grants broadcast. One operation in flight at a time.

Parameters:
- TAG_WIDTH, 7, width of the rename/ROB tag carried with each operation.
- MISS_TIMEOUT, 255, maximum cycles to wait for cache_hit before flagging a bus error.

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; abort any in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- req_unsigned  in  1  zero-extend a load (1) or sign-extend it (0).
- req_address  in  32  effective byte address.
- req_data  in  32  store data, right-aligned.
- req_tag  in  TAG_WIDTH  destination/ROB tag.
- cache_hit  in  1  cache access completes this cycle (read data valid).
- cache_data  inout  32  bidirectional cache data.
- cache_address  out  32  word-aligned address (bits 1:0 = 0).
- cache_read  out  1  read request.
- cache_write  out  1  write request.
- result_valid  out  1  result waiting for broadcast.
- result_ready  in  1  bus granted; result consumed this cycle.
- result_data  out  32  load value (0 for stores).
- result_tag  out  TAG_WIDTH  tag of the result.
- result_error  out  1  misaligned access or cache timeout.

Behaviour:
- Reset: state IDLE; req_ready=1; cache_read=0; cache_write=0; cache_address=0; cache_data high-Z; result_valid=0; result_data=0; result_tag=0; result_error=0; timeout counter=0.
- FSM states: IDLE, LOAD, STORE_RD, STORE_WR, RESULT.
- IDLE:
  - req_ready=1.
  - On req_valid: latch all request fields, then choose the next state:
    - load -> LOAD
    - byte/half store -> STORE_RD
    - word store -> STORE_WR
    - misaligned (see Optional Feature) -> RESULT with error=1 and no cache access.
  - req_ready=0 in every other state.
- LOAD:
  - cache_read=1, cache_address={addr[31:2],2'b00}.
  - On the cache_hit clock edge: select the byte/half at addr[1:0] (little-endian), sign- or zero-extend to 32 bits, and latch it into result_data. Next state RESULT.
- STORE_RD:
  - Same read as LOAD.
  - On cache_hit: merge req_data low byte/half into the read word at addr[1:0]; latch as the write word. Next state STORE_WR.
- STORE_WR:
  - cache_write=1; cache_data driven with the write word (driven only in this state).
  - On cache_hit: result_data=0. Next state RESULT.
- Timeout:
  - Counter increments each cycle in LOAD, STORE_RD and STORE_WR without cache_hit.
  - Counter reaches MISS_TIMEOUT -> RESULT with result_error=1 and result_data=0.
  - Counter clears on every state change.
- RESULT:
  - result_valid=1; result_tag and result_data held stable.
  - On result_ready -> IDLE. The next request can be accepted the cycle after.
- Latency: word load with an immediate hit accepted at edge N gives result_valid at N+2. A sub-word store with immediate hits gives result_valid at N+3.
- flush:
  - Any state: next state IDLE; read/write/result_valid deassert next cycle; no result is broadcast.
  - A write not yet acknowledged by cache_hit is abandoned.
  - flush has priority over cache_hit and result_ready in the same cycle.
  - flush together with req_valid in IDLE: request dropped.
- cache_hit is ignored in IDLE and RESULT.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, skips the cache and goes straight to RESULT with result_error=1 and result_data=0.
- Undefined: the address is force-aligned (half clears bit 0, word clears bits 1:0), the access proceeds normally, and result_error is set only by timeout.

Test Plan:
- Preload cache word 0x1000=0x8899AABB; load byte unsigned from 0x1002, immediate hit, result_ready=1 -> result_data=0x00000099, result_valid at accept+2, tag echoed.
- Same word; load half signed from 0x1002 -> result_data=0xFFFF8899. Load word from 0x1000 -> 0x8899AABB.
- Byte store of 0x5A to 0x1001 -> one read, then a write of 0x8899 5ABB; cache_data high-Z outside STORE_WR; result_data=0.
- Load with cache_hit withheld -> result_error=1 exactly MISS_TIMEOUT cycles after entering LOAD. Separately, hit after 3 wait cycles -> correct data, no error.
- Store with flush asserted during STORE_RD -> no cache_write ever; result_valid stays 0; req_ready=1 the next cycle.
- Word load from 0x1002: with the macro -> error=1 and no cache_read; without it -> returns 0x8899AABB. Also: result_ready held low for 5 cycles -> result is stable and req_ready stays 0.
